// File: rtl/noc_pkg.sv
// Shared NoC types: flit layout, port directions and output-arbiter states.
package noc_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      last;
    logic [NOC_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef enum logic [2:0] {
    DIR_E,
    DIR_W,
    DIR_N,
    DIR_S,
    DIR_IP
  } dir_e;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/noc_rr_arb.sv
// N-way round-robin pick: first requester scanning upward from ptr+1, wrapping.
module noc_rr_arb #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    return IDX_W'(s % N);
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = wrap_idx(ptr, i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/noc_out_port_arb.sv
// Wormhole output-port arbiter: round-robin between packets, lock until tail, registered output.
module noc_out_port_arb
  import noc_pkg::*;
#(
  parameter  int unsigned N_IN       = 5,
  parameter  int unsigned DATA_WIDTH = NOC_DATA_WIDTH,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned IDX_W      = $clog2(N_IN)
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic [N_IN-1:0]                 in_empty,
  input  logic [N_IN*(DATA_WIDTH+1)-1:0]  in_rd_data,
  output logic [N_IN-1:0]                 in_rd_en,
  input  logic [N_IN-1:0]                 in_mask,
  input  logic                            Ready,
  output logic                            Valid,
  output logic                            Last_out,
  output logic [DATA_WIDTH-1:0]           Data_out,
  output logic [IDX_W-1:0]                owner,
  output logic                            busy,
  output logic [CNT_W-1:0]                pkt_count
);

  localparam int unsigned FW = DATA_WIDTH + 1;
  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

  logic [FW-1:0]    heads [N_IN];
  logic [0:0]       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic             busy_nxt;
  logic             slot_free;
  logic [N_IN-1:0]  req;
  logic [N_IN-1:0]  win_grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             load;
  logic [FW-1:0]    load_flit;
  logic [N_IN-1:0]  rd_en;

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      heads[i] = in_rd_data[i*FW +: FW];
    end
  end

  assign slot_free = !Valid || Ready;
  assign req       = ~in_empty & in_mask;

  noc_rr_arb #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Next-state, pop strobe and output-register load decision.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    busy_nxt   = busy;
    rd_en      = '0;
    load       = 1'b0;
    load_flit  = heads[owner];
    if (state == ST_IDLE) begin
      if (win_any && slot_free) begin
        rd_en      = win_grant;
        load       = 1'b1;
        load_flit  = heads[win_idx];
        rr_ptr_nxt = win_idx;
        if (!heads[win_idx][FW-1]) begin
          state_nxt = ST_LOCKED;
          owner_nxt = win_idx;
          busy_nxt  = 1'b1;
        end
      end
    end else begin
      // Owner is served regardless of its mask bit; an empty owner FIFO is a bubble.
      if (!in_empty[owner] && slot_free) begin
        rd_en     = N_IN'(1) << owner;
        load      = 1'b1;
        load_flit = heads[owner];
        if (heads[owner][FW-1]) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      end
    end
  end

  assign in_rd_en = nreset ? '0 : rd_en;

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state  <= ST_IDLE;
      rr_ptr <= IDX_W'(N_IN - 1);
      owner  <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      busy   <= busy_nxt;
    end
  end

  // Single-entry output register; a load wins over a same-cycle drain.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      Valid    <= 1'b0;
      Last_out <= 1'b0;
      Data_out <= '0;
    end else if (load) begin
      Valid    <= 1'b1;
      Last_out <= load_flit[FW-1];
      Data_out <= load_flit[DATA_WIDTH-1:0];
    end else if (Ready) begin
      Valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      pkt_count <= '0;
    end else if (Valid && Ready && Last_out) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule
